// File: rtl/arb_mux_n_1_pkg.sv
// Shared constants and elaboration helpers for the N:1 registered arbitrating mux.
package arb_mux_n_1_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/arb_mux_n_1_rr_arbiter.sv
// Round-robin priority scan starting at ptr; ptr moves past the winner on each accepted grant.
module rr_arbiter
  import arb_mux_n_1_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_vld
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] idx_c;
  logic            vld_c;
  int unsigned     best_i;

  // Pick the requester with the smallest wrap-around distance from ptr.
  always_comb begin
    int unsigned ptr_i;
    int unsigned best_d;
    int unsigned d;
    ptr_i  = 32'(ptr_q);
    best_d = N;
    best_i = 0;
    idx_c  = '0;
    vld_c  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      d = (i >= ptr_i) ? (i - ptr_i) : (i + N - ptr_i);
      if (req[i] && (d < best_d)) begin
        best_d = d;
        best_i = i;
        idx_c  = SELW'(i);
        vld_c  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && vld_c) ptr_d = (best_i == N - 1) ? '0 : SELW'(best_i + 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign grant_idx = idx_c;
  assign grant_vld = vld_c;

endmodule

// File: rtl/arb_mux_n_1.sv
// N-input registered mux with valid/ready handshake; external select or round-robin arbitration.
module arb_mux_n_1
  import arb_mux_n_1_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2,
  parameter int unsigned MODE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src
);

  if (SELW != clog2(N)) begin : g_selw_check
    $fatal(1, "arb_mux_n_1: SELW must equal clog2(N)");
  end

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SELW-1:0]    out_src_q, out_src_d;
  logic [SELW-1:0]    cand;
  logic               cand_vld;
  logic               load;
  logic               transfer;
  logic [N-1:0]       in_ready_c;
  logic [WIDTH-1:0]   mux_data;

  assign load = !out_valid_q || out_ready;

  if (MODE == MODE_RR) begin : g_rr
    logic sel_unused;
    assign sel_unused = ^sel;
    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (in_valid),
      .advance   (transfer),
      .grant_idx (cand),
      .grant_vld (cand_vld)
    );
  end else begin : g_sel
    assign cand     = sel;
    assign cand_vld = 1'b1;
  end

  // An out-of-range sel matches no bit, so no channel is offered.
  always_comb begin
    in_ready_c = '0;
    mux_data   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand == SELW'(i)) begin
        in_ready_c[i] = load && cand_vld;
        mux_data      = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign transfer = |(in_valid & in_ready_c);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = cand;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
